seq_addsub_nbit: RTL and testbench

Parametrised multi-cycle adder/subtractor, successor to the fixed 8-bit ripple-carry adder.
- Computes a+b or a−b over WIDTH bits, CHUNK bits per clock, with a ripple carry held in a register between chunks.
- Uses a start/busy/done handshake and reports carry-out and signed overflow.
- Sits beside the combinational adders as the area-lean arithmetic unit for the lab datapath.

---
 rtl/seq_addsub_nbit.sv | 155 +++++++++++++++
 tb/tb_seq_addsub_nbit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/seq_addsub_nbit.sv
// seq_addsub_nbit: multi-cycle adder/subtractor.
//   Computes a+b or a-b over WIDTH bits, CHUNK bits per clock, with the ripple
//   carry held in a register between chunks. NCYC = WIDTH/CHUNK cycles per op.
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous, active-high reset
//   start - request an operation (sampled when not busy, i.e. IDLE or DONE)
//   sub   - 0: a+b, 1: a-b (sampled with start)
//   a, b  - WIDTH-bit operands (sampled with start)
//   busy  - high while chunks are being processed
//   done  - one-cycle pulse; sum/cout/ovf are updated for that cycle
//   sum   - registered result, held until the next done
//   cout  - carry out of the MSB (subtract: 1 = no borrow)
//   ovf   - two's-complement signed overflow
// Optional feature: define SEQ_ADDSUB_SATURATE_EN to clamp sum on overflow.
module seq_addsub_nbit #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCYC = WIDTH / CHUNK;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             asign_q, asign_d;
  logic             bsign_q, bsign_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] res_shift;
  logic             ovf_calc;
  logic [WIDTH-1:0] sum_final;

  // Per-chunk datapath: low CHUNK bits of the operand shift registers plus carry.
  assign chunk_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, carry_q};

  // New chunk enters at the MSB end; after NCYC shifts the first chunk sits at bit 0.
  assign res_shift = (res_q >> CHUNK) | (WIDTH'(chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK));

  // bsign_q already holds the inverted B sign for subtract.
  assign ovf_calc = (asign_q == bsign_q) && (res_shift[WIDTH-1] != asign_q);

`ifdef SEQ_ADDSUB_SATURATE_EN
  assign sum_final = !ovf_calc ? res_shift
                   : (asign_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}});
`else
  assign sum_final = res_shift;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    asign_d = asign_q;
    bsign_d = bsign_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub;
          asign_d = a[WIDTH-1];
          bsign_d = sub ? ~b[WIDTH-1] : b[WIDTH-1];
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        carry_d = chunk_sum[CHUNK];
        res_d   = res_shift;
        cnt_d   = cnt_q + 1'b1;
        // Outputs are loaded on the edge that enters DONE, so they are valid
        // exactly while done is high and never show partial results.
        if (cnt_q == CW'(NCYC - 1)) begin
          state_d = S_DONE;
          sum_d   = sum_final;
          cout_d  = chunk_sum[CHUNK];
          ovf_d   = ovf_calc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      asign_q <= 1'b0;
      bsign_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      asign_q <= asign_d;
      bsign_q <= bsign_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_addsub_nbit.sv
// Testbench for seq_addsub_nbit: WIDTH=16 with CHUNK=4 (u_dut) and CHUNK=16 (u_dut1).
module tb_seq_addsub_nbit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, sub = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        busy, done, cout, ovf;
  logic [15:0] sum;
  logic        start1 = 1'b0, sub1 = 1'b0;
  logic [15:0] a1 = '0, b1 = '0;
  logic        busy1, done1, cout1, ovf1;
  logic [15:0] sum1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_addsub_nbit #(.WIDTH(16), .CHUNK(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  seq_addsub_nbit #(.WIDTH(16), .CHUNK(16)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  // Reference: signed integer arithmetic for value/overflow, unsigned compare for carry.
  function automatic logic [17:0] model(input logic [15:0] ma, mb, input logic ms);
    int sa, sb, r;
    logic [15:0] res;
    logic c, v;
    sa  = int'($signed(ma));
    sb  = int'($signed(mb));
    r   = ms ? sa - sb : sa + sb;
    v   = (r > 32767) || (r < -32768);
    res = 16'(r);
    c   = ms ? (ma >= mb) : ((32'(ma) + 32'(mb)) > 32'd65535);
`ifdef SEQ_ADDSUB_SATURATE_EN
    if (v) res = (r > 0) ? 16'h7FFF : 16'h8000;
`endif
    return {res, c, v};
  endfunction

  // Issues one operation on the selected instance and waits (bounded) for done.
  task automatic do_op(input bit one, input logic [15:0] ta, tb, input logic ts,
                       output logic [15:0] rs, output logic rc, rv,
                       output int lat, output int bcnt);
    @(posedge clk); #1;
    if (one) begin start1 = 1'b1; a1 = ta; b1 = tb; sub1 = ts; end
    else     begin start  = 1'b1; a  = ta; b  = tb; sub  = ts; end
    @(posedge clk); #1;
    start = 1'b0; start1 = 1'b0;
    lat = 0; bcnt = 0;
    while (!(one ? done1 : done) && lat < 20) begin
      if (one ? busy1 : busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    rs = one ? sum1 : sum;
    rc = one ? cout1 : cout;
    rv = one ? ovf1 : ovf;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (sum !== 16'h0)   begin errors++; $display("FAIL reset_sum got=%h want=0000", sum); end
    checks++; if (cout !== 1'b0)   begin errors++; $display("FAIL reset_cout got=%b want=0", cout); end
    checks++; if (ovf !== 1'b0)    begin errors++; $display("FAIL reset_ovf got=%b want=0", ovf); end
    checks++; if (sum1 !== 16'h0 || busy1 !== 1'b0) begin errors++; $display("FAIL reset_dut1 got sum=%h busy=%b want 0000/0", sum1, busy1); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [15:0] rs; logic rc, rv; int lat, bc;
    logic [15:0] exp_sat;
    do_op(0, 16'h1234, 16'h4321, 1'b0, rs, rc, rv, lat, bc);
    checks++; if (lat !== 4)        begin errors++; $display("FAIL add_latency got=%0d want=4", lat); end
    checks++; if (bc !== 4)         begin errors++; $display("FAIL add_busy_cycles got=%0d want=4", bc); end
    checks++; if (rs !== 16'h5555)  begin errors++; $display("FAIL add_sum got=%h want=5555", rs); end
    checks++; if ({rc, rv} !== 2'b00) begin errors++; $display("FAIL add_flags got=%b%b want=00", rc, rv); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || sum !== 16'h5555) begin errors++; $display("FAIL add_hold got done=%b sum=%h want 0/5555", done, sum); end

    do_op(0, 16'hFFFF, 16'h0001, 1'b0, rs, rc, rv, lat, bc);
    checks++; if (rs !== 16'h0000 || rc !== 1'b1 || rv !== 1'b0) begin errors++; $display("FAIL wrap got sum=%h c=%b v=%b want 0000/1/0", rs, rc, rv); end

`ifdef SEQ_ADDSUB_SATURATE_EN
    exp_sat = 16'h7FFF;
`else
    exp_sat = 16'h8000;
`endif
    do_op(0, 16'h7FFF, 16'h0001, 1'b0, rs, rc, rv, lat, bc);
    checks++; if (rs !== exp_sat || rc !== 1'b0 || rv !== 1'b1) begin errors++; $display("FAIL pos_ovf got sum=%h c=%b v=%b want %h/0/1", rs, rc, rv, exp_sat); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] rs, exp2; logic rc, rv; int lat, bc, cyc;
    do_op(0, 16'h0005, 16'h0007, 1'b1, rs, rc, rv, lat, bc);
    checks++; if (rs !== 16'hFFFE || rc !== 1'b0 || rv !== 1'b0) begin errors++; $display("FAIL sub_borrow got sum=%h c=%b v=%b want fffe/0/0", rs, rc, rv); end
    // Still in the DONE cycle: issue the next operation now.
    start = 1'b1; a = 16'h8000; b = 16'h0001; sub = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1 || sum !== 16'hFFFE) begin errors++; $display("FAIL b2b_accept got busy=%b sum=%h want 1/fffe", busy, sum); end
    cyc = 0;
    while (!done && cyc < 20) begin @(posedge clk); #1; cyc++; end
`ifdef SEQ_ADDSUB_SATURATE_EN
    exp2 = 16'h8000;
`else
    exp2 = 16'h7FFF;
`endif
    checks++; if (cyc !== 4) begin errors++; $display("FAIL b2b_latency got=%0d want=4", cyc); end
    checks++; if (sum !== exp2 || cout !== 1'b1 || ovf !== 1'b1) begin errors++; $display("FAIL neg_ovf got sum=%h c=%b v=%b want %h/1/1", sum, cout, ovf, exp2); end
  endtask

  task automatic test_interference();
    int ndone; logic [15:0] seen;
    @(posedge clk); #1;
    start = 1'b1; a = 16'h1234; b = 16'h4321; sub = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; a = 16'hAAAA; b = 16'h1111; sub = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; seen = '0;
    for (int i = 0; i < 10; i++) begin
      if (done) begin ndone++; seen = sum; end
      @(posedge clk); #1;
    end
    checks++; if (ndone !== 1)        begin errors++; $display("FAIL ignore_start_dones got=%0d want=1", ndone); end
    checks++; if (seen !== 16'h5555)  begin errors++; $display("FAIL ignore_start_sum got=%h want=5555", seen); end

    start = 1'b1; a = 16'h1111; b = 16'h2222; sub = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || sum !== 16'h0) begin errors++; $display("FAIL abort got busy=%b done=%b sum=%h want 0/0/0000", busy, done, sum); end
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) ndone++;
      @(posedge clk); #1;
    end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL abort_no_done got=%0d want=0", ndone); end

    rst = 1'b1; start = 1'b1; a = 16'h0001; b = 16'h0001; sub = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_beats_start got busy=%b want=0", busy); end
  endtask

  task automatic test_single_cycle();
    logic [15:0] rs; logic rc, rv; int lat, bc;
    do_op(1, 16'h00FF, 16'h0F01, 1'b0, rs, rc, rv, lat, bc);
    checks++; if (lat !== 1 || bc !== 1) begin errors++; $display("FAIL single_latency got lat=%0d busy=%0d want 1/1", lat, bc); end
    checks++; if (rs !== 16'h1000 || rc !== 1'b0 || rv !== 1'b0) begin errors++; $display("FAIL single_sum got sum=%h c=%b v=%b want 1000/0/0", rs, rc, rv); end
  endtask

  task automatic test_random();
    logic [15:0] ra, rb, rs; logic rsub, rc, rv; logic [17:0] exp; int lat, bc; bit one;
    for (int i = 0; i < 40; i++) begin
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rsub = 1'($urandom);
      one  = (i % 4) == 3;
      if (i % 5 == 0) ra = (ra[0]) ? 16'h7FFF : 16'h8000;
      exp = model(ra, rb, rsub);
      do_op(one, ra, rb, rsub, rs, rc, rv, lat, bc);
      checks++; if (lat !== (one ? 1 : 4)) begin errors++; $display("FAIL rand_latency[%0d] got=%0d want=%0d", i, lat, one ? 1 : 4); end
      checks++; if ({rs, rc, rv} !== exp) begin errors++; $display("FAIL rand_result[%0d] a=%h b=%h sub=%b got sum=%h c=%b v=%b want sum=%h c=%b v=%b", i, ra, rb, rsub, rs, rc, rv, exp[17:2], exp[1], exp[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_interference();
    test_single_cycle();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
